// File: rtl/multicycle_datapath.sv
// multicycle_datapath: multi-cycle RV32I-subset core (lw, sw, add/sub/and/or/slt,
// addi/andi/ori/slti, beq, jal) sharing one req/ready memory port for fetch and data.
// Optional feature: define PERF_COUNTERS_EN to add o_cycle_cnt / o_instret_cnt.
module multicycle_datapath #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     NREGS    = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   output logic            o_mem_req,
   output logic            o_mem_we,
   output logic [XLEN-1:0] o_mem_addr,
   output logic [XLEN-1:0] o_mem_wdata,
   input  logic [XLEN-1:0] i_mem_rdata,
   input  logic            i_mem_ready,
   output logic [XLEN-1:0] o_pc,
   output logic            o_trap,
`ifdef PERF_COUNTERS_EN
   output logic [63:0]     o_cycle_cnt,
   output logic [63:0]     o_instret_cnt,
`endif
   output logic            o_instr_done
);

   localparam int unsigned RegAw = $clog2(NREGS);

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpAlu    = 7'b0110011;
   localparam logic [6:0] OpAluImm = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;

   typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StTrap} state_t;

   state_t          r_state;
   state_t          w_state_d;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_oldpc;
   logic [31:0]     r_ir;
   logic [XLEN-1:0] r_a;
   logic [XLEN-1:0] r_b;
   logic [XLEN-1:0] r_aluout;
   logic [XLEN-1:0] r_mdr;
   logic [XLEN-1:0] r_rf [NREGS];

   // Instruction fields
   logic [6:0] w_opcode;
   logic [4:0] w_rd;
   logic [4:0] w_rs1;
   logic [4:0] w_rs2;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;

   assign w_opcode = r_ir[6:0];
   assign w_rd     = r_ir[11:7];
   assign w_funct3 = r_ir[14:12];
   assign w_rs1    = r_ir[19:15];
   assign w_rs2    = r_ir[24:20];
   assign w_funct7 = r_ir[31:25];

   // Decode: IR is stable from DECODE through WB, so decode stays combinational
   logic w_is_load, w_is_store, w_is_alu, w_is_alui, w_is_beq, w_is_jal;
   logic w_f3_alu_ok;
   logic w_uses_rd, w_uses_rs1, w_uses_rs2;
   logic w_reg_ok, w_legal;

   assign w_f3_alu_ok = (w_funct3 == 3'b000) || (w_funct3 == 3'b111) ||
                        (w_funct3 == 3'b110) || (w_funct3 == 3'b010);
   assign w_is_load   = (w_opcode == OpLoad)  && (w_funct3 == 3'b010);
   assign w_is_store  = (w_opcode == OpStore) && (w_funct3 == 3'b010);
   assign w_is_alu    = (w_opcode == OpAlu) &&
                        (((w_funct7 == 7'b0000000) && w_f3_alu_ok) ||
                         ((w_funct7 == 7'b0100000) && (w_funct3 == 3'b000)));
   assign w_is_alui   = (w_opcode == OpAluImm) && w_f3_alu_ok;
   assign w_is_beq    = (w_opcode == OpBranch) && (w_funct3 == 3'b000);
   assign w_is_jal    = (w_opcode == OpJal);

   assign w_uses_rd  = w_is_load | w_is_alu | w_is_alui | w_is_jal;
   assign w_uses_rs1 = w_is_load | w_is_store | w_is_alu | w_is_alui | w_is_beq;
   assign w_uses_rs2 = w_is_store | w_is_alu | w_is_beq;

   // Only register fields the instruction actually uses must fit in NREGS
   assign w_reg_ok = (!w_uses_rd  || (32'(w_rd)  < NREGS)) &&
                     (!w_uses_rs1 || (32'(w_rs1) < NREGS)) &&
                     (!w_uses_rs2 || (32'(w_rs2) < NREGS));
   assign w_legal  = (w_is_load | w_is_store | w_is_alu | w_is_alui | w_is_beq | w_is_jal) &&
                     w_reg_ok;

   // Immediate generation, sign-extended to XLEN
   logic [XLEN-1:0] w_imm;
   always_comb begin
      w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
      if (w_is_store) begin
         w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
      end else if (w_is_beq) begin
         w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
      end else if (w_is_jal) begin
         w_imm = {{(XLEN-20){r_ir[31]}}, r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
      end
   end

   // ALU for R/I-type; address and branch targets have dedicated adders
   logic [XLEN-1:0] w_alu_b, w_alu_res, w_addr_sum, w_br_target, w_wb_data;
   assign w_alu_b     = w_is_alu ? r_b : w_imm;
   assign w_addr_sum  = r_a + w_imm;
   assign w_br_target = r_oldpc + w_imm;
   assign w_wb_data   = w_is_load ? r_mdr : r_aluout;

   // ALU operation select
   always_comb begin
      w_alu_res = r_a + w_alu_b;
      case (w_funct3)
         3'b000:  w_alu_res = (w_is_alu && w_funct7[5]) ? (r_a - w_alu_b) : (r_a + w_alu_b);
         3'b111:  w_alu_res = r_a & w_alu_b;
         3'b110:  w_alu_res = r_a | w_alu_b;
         3'b010:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(w_alu_b))};
         default: w_alu_res = r_a + w_alu_b;
      endcase
   end

   // Register file reads, x0 reads as zero
   logic [XLEN-1:0] w_rs1_val, w_rs2_val;
   logic            w_rf_we;
   assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_rf[w_rs1[RegAw-1:0]];
   assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_rf[w_rs2[RegAw-1:0]];
   assign w_rf_we   = i_rst_n && (r_state == StWb) && (w_rd != 5'd0);

   // Register file write (not cleared by reset)
   always_ff @(posedge i_clk) begin
      if (w_rf_we) begin
         r_rf[w_rd[RegAw-1:0]] <= w_wb_data;
      end
   end

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StFetch;
      end else begin
         r_state <= w_state_d;
      end
   end

   // FSM next state and memory-port / retire outputs
   always_comb begin
      w_state_d    = r_state;
      o_mem_req    = 1'b0;
      o_mem_we     = 1'b0;
      o_mem_addr   = r_pc;
      o_instr_done = 1'b0;
      unique case (r_state)
         StFetch: begin
            o_mem_req = 1'b1;
            if (i_mem_ready) w_state_d = StDecode;
         end
         StDecode: w_state_d = w_legal ? StExec : StTrap;
         StExec: begin
            if (w_is_load || w_is_store) begin
               w_state_d = StMem;
            end else if (w_is_beq) begin
               o_instr_done = 1'b1;
               w_state_d    = StFetch;
            end else begin
               w_state_d = StWb;
            end
         end
         StMem: begin
            o_mem_req  = 1'b1;
            o_mem_addr = r_aluout;
            o_mem_we   = w_is_store;
            if (i_mem_ready) begin
               if (w_is_store) begin
                  o_instr_done = 1'b1;
                  w_state_d    = StFetch;
               end else begin
                  w_state_d = StWb;
               end
            end
         end
         StWb: begin
            o_instr_done = 1'b1;
            w_state_d    = StFetch;
         end
         StTrap:  w_state_d = StTrap;
         default: w_state_d = StFetch;
      endcase
      // Request must drop the moment reset is asserted, before the async flop settles
      if (!i_rst_n) begin
         o_mem_req = 1'b0;
         o_mem_we  = 1'b0;
      end
   end

   // Datapath registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pc     <= RESET_PC;
         r_oldpc  <= RESET_PC;
         r_ir     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_aluout <= '0;
         r_mdr    <= '0;
      end else begin
         case (r_state)
            StFetch: begin
               if (i_mem_ready) begin
                  r_ir    <= i_mem_rdata[31:0];
                  r_oldpc <= r_pc;
                  r_pc    <= r_pc + XLEN'(4);
               end
            end
            StDecode: begin
               r_a <= w_rs1_val;
               r_b <= w_rs2_val;
            end
            StExec: begin
               if (w_is_alu || w_is_alui) begin
                  r_aluout <= w_alu_res;
               end else if (w_is_load || w_is_store) begin
                  r_aluout <= w_addr_sum;
               end else if (w_is_beq) begin
                  if (r_a == r_b) r_pc <= w_br_target;
               end else if (w_is_jal) begin
                  r_pc     <= w_br_target;
                  r_aluout <= r_oldpc + XLEN'(4);
               end
            end
            StMem: begin
               if (i_mem_ready && w_is_load) r_mdr <= i_mem_rdata;
            end
            default: ;
         endcase
      end
   end

   assign o_pc        = r_pc;
   assign o_trap      = (r_state == StTrap);
   assign o_mem_wdata = r_b;

`ifdef PERF_COUNTERS_EN
   logic [63:0] r_cycle_cnt;
   logic [63:0] r_instret_cnt;

   // Free-running cycle and retired-instruction counters
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cycle_cnt   <= '0;
         r_instret_cnt <= '0;
      end else begin
         r_cycle_cnt <= r_cycle_cnt + 64'd1;
         if (o_instr_done) r_instret_cnt <= r_instret_cnt + 64'd1;
      end
   end

   assign o_cycle_cnt   = r_cycle_cnt;
   assign o_instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: unified memory model with scripted wait states,
// table-driven ALU vectors, hand sequences and randomized programs vs. an ISA model.
module tb_multicycle_datapath;

   localparam int MemWords = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_req, mem_we, mem_ready, trap, instr_done;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
`ifdef PERF_COUNTERS_EN
   logic [63:0] cycle_cnt, instret_cnt;
`endif

   always #5 clk = ~clk;

   multicycle_datapath #(.XLEN(32), .RESET_PC(32'h0), .NREGS(32)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .o_mem_req    (mem_req),
      .o_mem_we     (mem_we),
      .o_mem_addr   (mem_addr),
      .o_mem_wdata  (mem_wdata),
      .i_mem_rdata  (mem_rdata),
      .i_mem_ready  (mem_ready),
      .o_pc         (pc),
      .o_trap       (trap),
`ifdef PERF_COUNTERS_EN
      .o_cycle_cnt  (cycle_cnt),
      .o_instret_cnt(instret_cnt),
`endif
      .o_instr_done (instr_done)
   );

   // Memory: imem is preloaded by the test, wmem holds DUT stores
   logic [31:0]         imem [MemWords];
   logic [31:0]         wmem [MemWords];
   logic [MemWords-1:0] wvalid;
   int                  waits [64];
   int                  widx;
   int                  wait_cnt;
   logic [9:0]          midx;

   assign midx      = mem_addr[11:2];
   assign mem_rdata = wvalid[midx] ? wmem[midx] : imem[midx];
   assign mem_ready = rst_n && (wait_cnt >= waits[widx]);

   // Each transfer waits waits[widx] cycles before ready
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= 0;
         widx     <= 0;
         wvalid   <= '0;
      end else if (mem_req) begin
         if (mem_ready) begin
            wait_cnt <= 0;
            widx     <= (widx + 1) % 64;
            if (mem_we) begin
               wmem[midx]   <= mem_wdata;
               wvalid[midx] <= 1'b1;
            end
         end else begin
            wait_cnt <= wait_cnt + 1;
         end
      end
   end

   int n_vec = 0;
   int n_bad = 0;
   int cyc;
   int ret_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rd_word(input int addr);
      int i;
      i = addr / 4;
      return wvalid[i] ? wmem[i] : imem[i];
   endfunction

   // Instruction encoders
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                         input logic [2:0] f3, input int rd);
      return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                         input int rd, input logic [6:0] opc);
      logic [11:0] im;
      im = 12'(imm);
      return {im, 5'(rs1), f3, 5'(rd), opc};
   endfunction
   function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
      return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
   endfunction
   function automatic logic [31:0] lw(input int rd, input int imm, input int rs1);
      return enc_i(imm, rs1, 3'b010, rd, 7'b0000011);
   endfunction
   function automatic logic [31:0] sw(input int rs2, input int imm, input int rs1);
      logic [11:0] im;
      im = 12'(imm);
      return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] beq(input int rs1, input int rs2, input int imm);
      logic [12:0] im;
      im = 13'(imm);
      return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'b000, im[4:1], im[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] jal(input int rd, input int imm);
      logic [20:0] im;
      im = 21'(imm);
      return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
   endfunction

   // Reference ALU: 0 add, 1 sub, 2 and, 3 or, 4 slt
   function automatic logic [31:0] alu_ref(input int kind, input logic [31:0] a,
                                           input logic [31:0] b);
      case (kind)
         0: return a + b;
         1: return a - b;
         2: return a & b;
         3: return a | b;
         default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      endcase
   endfunction
   function automatic logic [2:0] kind_f3(input int kind);
      case (kind)
         2: return 3'b111;
         3: return 3'b110;
         4: return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   task automatic clear_prog();
      for (int i = 0; i < MemWords; i++) imem[i] = 32'h0;
      for (int i = 0; i < 64; i++) waits[i] = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc = 0;
      ret_q.delete();
   endtask

   // Run until n more instructions retire; returns just after the last retire edge
   task automatic run(input int n, input int budget, input string name);
      int got;
      got = 0;
      for (int c = 0; c < budget && got < n; c++) begin
         @(negedge clk);
         cyc++;
         if (instr_done) begin
            ret_q.push_back(cyc);
            got++;
         end
      end
      check({name, " retired"}, 32'(got), 32'(n));
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [31:0] instr;
      logic [31:0] x1v;
      logic [31:0] x2v;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[14];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{enc_r(7'h00, 2, 1, 3'b000, 3), 32'd5, 32'd7, 32'd12};
      vecs[1]  = '{enc_r(7'h20, 2, 1, 3'b000, 3), 32'd5, 32'd7, 32'hFFFF_FFFE};
      vecs[2]  = '{enc_r(7'h00, 2, 1, 3'b111, 3), 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F};
      vecs[3]  = '{enc_r(7'h00, 2, 1, 3'b110, 3), 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF};
      vecs[4]  = '{enc_r(7'h00, 2, 1, 3'b010, 3), 32'hFFFF_FFFF, 32'd1, 32'd1};
      vecs[5]  = '{enc_r(7'h00, 2, 1, 3'b010, 3), 32'd1, 32'hFFFF_FFFF, 32'd0};
      vecs[6]  = '{enc_r(7'h00, 2, 1, 3'b000, 3), 32'hFFFF_FFFF, 32'd2, 32'd1};
      vecs[7]  = '{enc_i(-1, 1, 3'b000, 3, 7'b0010011), 32'd0, 32'd0, 32'hFFFF_FFFF};
      vecs[8]  = '{enc_i(32'h0F0, 1, 3'b111, 3, 7'b0010011), 32'h1234_5678, 32'd0, 32'h70};
      vecs[9]  = '{enc_i(-2048, 1, 3'b110, 3, 7'b0010011), 32'h123, 32'd0, 32'hFFFF_F923};
      vecs[10] = '{enc_i(-5, 1, 3'b010, 3, 7'b0010011), 32'hFFFF_FFFA, 32'd0, 32'd1};
      vecs[11] = '{enc_i(5, 1, 3'b010, 3, 7'b0010011), 32'h8000_0000, 32'd0, 32'd1};
      vecs[12] = '{enc_i(-5, 1, 3'b010, 3, 7'b0010011), 32'hFFFF_FFFB, 32'd0, 32'd0};
      vecs[13] = '{enc_r(7'h20, 2, 1, 3'b000, 3), 32'h8000_0000, 32'd1, 32'h7FFF_FFFF};

      clear_prog();
      // Reset state while reset is held low
      repeat (3) @(posedge clk);
      #1;
      check("reset pc", pc, 32'h0);
      check("reset trap", 32'(trap), 32'd0);
      check("reset mem_req", 32'(mem_req), 32'd0);
      check("reset instr_done", 32'(instr_done), 32'd0);
`ifdef PERF_COUNTERS_EN
      check("reset cycle_cnt", 32'(cycle_cnt), 32'd0);
      check("reset instret_cnt", 32'(instret_cnt), 32'd0);
`endif

      // Table: lw x1; lw x2; op -> x3; sw x3 (5+5+4+4 cycles, zero wait)
      for (int v = 0; v < 14; v++) begin
         clear_prog();
         imem[0]   = lw(1, 32'h300, 0);
         imem[1]   = lw(2, 32'h304, 0);
         imem[2]   = vecs[v].instr;
         imem[3]   = sw(3, 32'h308, 0);
         imem[192] = vecs[v].x1v;
         imem[193] = vecs[v].x2v;
         do_reset();
         run(4, 80, $sformatf("vec%0d", v));
         check($sformatf("vec%0d result", v), rd_word(32'h308), vecs[v].exp);
         check($sformatf("vec%0d cycles", v), 32'(cyc), 32'd18);
      end

      // addi/addi/add: retire at 4, 8, 12; pc=12
      clear_prog();
      imem[0] = addi(1, 0, 5);
      imem[1] = addi(2, 0, 7);
      imem[2] = enc_r(7'h00, 2, 1, 3'b000, 3);
      imem[3] = sw(3, 32'h100, 0);
      do_reset();
      run(3, 40, "seqA");
      check("seqA retire1", 32'(ret_q[0]), 32'd4);
      check("seqA retire2", 32'(ret_q[1]), 32'd8);
      check("seqA retire3", 32'(ret_q[2]), 32'd12);
      check("seqA pc", pc, 32'd12);
`ifdef PERF_COUNTERS_EN
      check("seqA cycle_cnt", 32'(cycle_cnt), 32'd12);
      check("seqA instret_cnt", 32'(instret_cnt), 32'd3);
`endif
      run(1, 20, "seqA store");
      check("seqA x3", rd_word(32'h100), 32'd12);

      // sw/lw with two wait cycles on every transfer
      clear_prog();
      for (int i = 0; i < 64; i++) waits[i] = 2;
      imem[0] = addi(3, 0, 12);
      imem[1] = sw(3, 16, 0);
      imem[2] = lw(4, 16, 0);
      imem[3] = sw(4, 32'h104, 0);
      do_reset();
      run(4, 100, "seqB");
      check("seqB addi cycles", 32'(ret_q[0]), 32'd6);
      check("seqB sw cycles", 32'(ret_q[1] - ret_q[0]), 32'd8);
      check("seqB lw cycles", 32'(ret_q[2] - ret_q[1]), 32'd9);
      check("seqB mem16", rd_word(16), 32'd12);
      check("seqB x4", rd_word(32'h104), 32'd12);

      // beq at 0x20: taken back to 0x18, not taken to 0x24
      for (int t = 0; t < 2; t++) begin
         clear_prog();
         imem[0] = addi(1, 0, 1);
         imem[1] = addi(2, 0, 2);
         imem[2] = jal(0, 24);
         imem[8] = (t == 0) ? beq(1, 1, -8) : beq(1, 2, -8);
         do_reset();
         run(4, 60, $sformatf("beq%0d", t));
         check($sformatf("beq%0d cycles", t), 32'(ret_q[3] - ret_q[2]), 32'd3);
         check($sformatf("beq%0d pc", t), pc, (t == 0) ? 32'h18 : 32'h24);
      end

      // jal x5,0x100 at 0x40; addi x0 discarded
      clear_prog();
      imem[0]  = jal(0, 32'h40);
      imem[16] = jal(5, 32'h100);
      imem[80] = addi(0, 0, 9);
      imem[81] = sw(5, 32'h200, 0);
      imem[82] = sw(0, 32'h204, 0);
      do_reset();
      run(2, 30, "jal");
      check("jal pc", pc, 32'h140);
      run(3, 40, "jal tail");
      check("jal x5", rd_word(32'h200), 32'h44);
      check("x0 zero", rd_word(32'h204), 32'h0);

      // Illegal instruction traps after DECODE and stays there
      clear_prog();
      imem[0] = 32'hFFFF_FFFF;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         cyc++;
         if (trap) break;
      end
      check("trap cycle", 32'(cyc), 32'd3);
      begin
         int odd;
         odd = 0;
         repeat (20) begin
            @(negedge clk);
            if (mem_req !== 1'b0 || trap !== 1'b1 || pc !== 32'd4 || instr_done !== 1'b0) odd++;
         end
         check("trap hold", 32'(odd), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("trap reset trap", 32'(trap), 32'd0);
      check("trap reset pc", pc, 32'h0);
      check("trap reset req", 32'(mem_req), 32'd0);

      // Reset asserted while a fetch is waiting on memory
      clear_prog();
      imem[0]  = addi(1, 0, 1);
      waits[0] = 5;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("midfetch req", 32'(mem_req), 32'd1);
      check("midfetch addr", mem_addr, 32'h0);
      rst_n = 1'b0;
      #1;
      check("midfetch drop req", 32'(mem_req), 32'd0);
      check("midfetch pc", pc, 32'h0);
`ifdef PERF_COUNTERS_EN
      check("midfetch cycle_cnt", 32'(cycle_cnt), 32'd0);
      check("midfetch instret_cnt", 32'(instret_cnt), 32'd0);
`endif

      // Randomized programs against the ISA-level model
      for (int it = 0; it < 15; it++) begin
         logic [31:0] regs [8];
         int          k, exp_cyc;
         clear_prog();
         k = 0;
         exp_cyc = 0;
         regs[0] = 32'h0;
         for (int r = 1; r < 8; r++) begin
            regs[r]         = $urandom;
            imem[192 + r]   = regs[r];
            imem[k]         = lw(r, 32'h300 + 4 * r, 0);
            k++;
            exp_cyc += 5;
         end
         for (int o = 0; o < 8; o++) begin
            int          kind, rd, rs1, rs2, imm;
            logic        is_i;
            logic [31:0] res;
            kind = int'($urandom_range(0, 4));
            is_i = (kind != 1) && ($urandom_range(0, 1) == 1);
            rd   = int'($urandom_range(0, 7));
            rs1  = int'($urandom_range(0, 7));
            rs2  = int'($urandom_range(0, 7));
            imm  = int'($urandom_range(0, 4095)) - 2048;
            res  = alu_ref(kind, regs[rs1], is_i ? 32'(imm) : regs[rs2]);
            imem[k] = is_i ? enc_i(imm, rs1, kind_f3(kind), rd, 7'b0010011)
                           : enc_r((kind == 1) ? 7'h20 : 7'h00, rs2, rs1, kind_f3(kind), rd);
            k++;
            exp_cyc += 4;
            if (rd != 0) regs[rd] = res;
         end
         for (int r = 1; r < 8; r++) begin
            imem[k] = sw(r, 32'h380 + 4 * r, 0);
            k++;
            exp_cyc += 4;
         end
         // 22 fetches + 7 loads + 7 stores
         for (int i = 0; i < 36; i++) begin
            waits[i] = int'($urandom_range(0, 3));
            exp_cyc += waits[i];
         end
         do_reset();
         run(22, 600, $sformatf("rand%0d", it));
         check($sformatf("rand%0d cycles", it), 32'((ret_q.size() > 0) ? ret_q[$] : 0),
               32'(exp_cyc));
         for (int r = 1; r < 8; r++) begin
            check($sformatf("rand%0d x%0d", it, r), rd_word(32'h380 + 4 * r), regs[r]);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Next-generation RISC-V RV32I-subset core datapath with an integrated control FSM.
- Executes one instruction over several cycles and shares a single memory port for instruction fetch and data access.
- Memory uses a req/ready handshake, so wait states are supported.
- Width, reset vector and register count are parametrised; sits between the top-level SoC and a unified memory.

Parameters:
- XLEN, 32, datapath/register/address width (≥32)
- RESET_PC, 0, pc value loaded on reset
- NREGS, 32, architectural registers (16 or 32); x0 hardwired to 0

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- mem_req  output  1  memory request valid
- mem_we  output  1  1=write (sw), 0=read
- mem_addr  output  XLEN  byte address (pc on fetch, ALUOut on lw/sw)
- mem_wdata  output  XLEN  store data (register B)
- mem_rdata  input  XLEN  read data, valid when mem_ready=1
- mem_ready  input  1  transfer completes on the edge where mem_req=mem_ready=1
- pc  output  XLEN  current program counter
- trap  output  1  sticky illegal-instruction flag
- instr_done  output  1  one-cycle pulse when an instruction retires

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC, state=FETCH, trap=0, instr_done=0; IR/A/B/ALUOut/MDR=0.
  - mem_req forced 0 while reset is low.
  - Register file is not cleared.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - On ready: IR<=mem_rdata, oldpc<=pc, pc<=pc+4, go to DECODE.
  - Otherwise hold; address stays stable.
- DECODE:
  - A<=rf[rs1], B<=rf[rs2], immExt built from opcode (I/S/B/J).
  - Unsupported opcode or funct -> TRAP.
  - Supported: lw(0000011), sw(0100011), R-type add/sub/and/or/slt, I-type addi/andi/ori/slti, beq, jal.
- EXEC:
  - R/I: ALUOut<=A op (B|imm) -> WB.
  - lw/sw: ALUOut<=A+imm -> MEM.
  - beq: if A==B then pc<=oldpc+imm; retire; go to FETCH.
  - jal: pc<=oldpc+imm, ALUOut<=oldpc+4 -> WB.
- MEM:
  - mem_req=1, mem_addr=ALUOut, mem_we=(sw), mem_wdata=B.
  - On ready: lw sets MDR<=mem_rdata and goes to WB; sw retires and goes to FETCH.
- WB:
  - rf[rd]<= MDR (lw) or ALUOut (others); writes to x0 discarded. Retire; go to FETCH.
- instr_done pulses in the retire cycle only.
- TRAP: mem_req=0, trap=1, pc frozen; leaves only on reset.
- Latency with zero-wait memory:
  - R/I/jal 4 cycles
  - lw 5
  - sw 4
  - beq 3
  - Each wait cycle with mem_ready=0 adds one cycle.
- Arithmetic:
  - Modulo 2^XLEN; pc wraps silently.
  - slt/slti signed.
  - Immediates sign-extended to XLEN.
  - Misaligned addresses passed through unchanged.
- Register file:
  - Same-cycle read of a register written in WB is not possible: DECODE always follows a later FETCH.
  - NREGS=16: rd/rs index ≥16 -> TRAP.
- Reset asserted mid-transfer: request dropped immediately; no register write occurs that cycle.

Optional Feature:
- Macro PERF_COUNTERS_EN.
- Defined: adds outputs cycle_cnt[63:0] (increments every cycle out of reset, including TRAP) and instret_cnt[63:0] (increments on instr_done). Both reset to 0 and wrap at 2^64.
- Undefined: ports absent, no counter logic.

Test Plan:
- Zero-wait memory, program `addi x1,x0,5; addi x2,x0,7; add x3,x1,x2` -> x3=12 after 12 cycles; instr_done pulses at cycles 4, 8, 12; pc=12.
- `sw x3,16(x0)` then `lw x4,16(x0)` with mem_ready low for 2 cycles per request -> memory[16]=12, x4=12, lw takes 5+4=9 cycles including the wait states on fetch and data.
- `beq x1,x1,-8` at pc=0x20 -> pc=0x18 after 3 cycles; with x1≠x2 (`beq x1,x2`) -> pc=0x24.
- `jal x5,0x100` at pc=0x40 -> x5=0x44, pc=0x140; `addi x0,x0,9` -> x0 reads 0.
- Instruction 0xFFFFFFFF -> trap=1 after DECODE, mem_req=0 forever; reset low mid-FETCH clears trap, pc=RESET_PC, mem_req=0 immediately.
- PERF_COUNTERS_EN: after the first test, cycle_cnt=12, instret_cnt=3; both reset to 0 on async reset.
